// File: rtl/pipe_controller_if.sv
// pipe_controller_if
//   Bundles the control-unit signals exchanged between the ARM pipeline
//   datapath and pipe_controller.
//   master : the datapath side; drives the instruction, ALU flags and flush,
//            and receives the control outputs.
//   slave  : the control unit side (pipe_controller).
//   Signals:
//     InstrD[19:0]  instruction bits [31:12] held in Decode
//     ALUFlags[3:0] {N,Z,C,V} from the Execute ALU
//     FlushE        bubble the D->E control register
//     RegSrcD, ImmSrcD            Decode-stage controls
//     ALUSrcE, ALUControlE, MemtoRegE, BranchTakenE   Execute-stage controls
//     MemWriteM, RegWriteM        Memory-stage controls
//     PCSrcW, MemtoRegW, RegWriteW  Writeback-stage controls
//     PCWrPendingF                a PC write is pending in D, E or M
interface pipe_controller_if #(
    parameter int ALUW = 3
);
    logic [19:0]     InstrD;
    logic [3:0]      ALUFlags;
    logic            FlushE;
    logic [1:0]      RegSrcD;
    logic [1:0]      ImmSrcD;
    logic            ALUSrcE;
    logic [ALUW-1:0] ALUControlE;
    logic            BranchTakenE;
    logic            MemWriteM;
    logic            MemtoRegE;
    logic            RegWriteM;
    logic            PCSrcW;
    logic            MemtoRegW;
    logic            RegWriteW;
    logic            PCWrPendingF;

    modport master (
        output InstrD, ALUFlags, FlushE,
        input  RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE,
        input  MemWriteM, MemtoRegE, RegWriteM, PCSrcW, MemtoRegW,
        input  RegWriteW, PCWrPendingF
    );

    modport slave (
        input  InstrD, ALUFlags, FlushE,
        output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE,
        output MemWriteM, MemtoRegE, RegWriteM, PCSrcW, MemtoRegW,
        output RegWriteW, PCWrPendingF
    );
endinterface

// File: rtl/pipe_controller.sv
// pipe_controller
//   Control unit of the 5-stage ARM pipeline. Decodes the instruction in
//   Decode, carries Execute/Memory/Writeback controls through pipeline
//   registers aligned with the datapath, holds the NZCV flag register and
//   evaluates condition codes in Execute.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset; clears every register
//     bus    pipe_controller_if.slave (instruction, flags, flush in;
//            all stage controls out)
//   There is no handshake: every stage advances on every clock edge, and a
//   stall is expressed by the hazard unit as FlushE.
module pipe_controller #(
    parameter int ALUW = 3
) (
    input  logic            clk,
    input  logic            reset,
    pipe_controller_if.slave bus
);

    typedef enum logic [1:0] {
        OP_DP   = 2'b00,
        OP_MEM  = 2'b01,
        OP_BR   = 2'b10,
        OP_NONE = 2'b11
    } op_e;

    localparam logic [ALUW-1:0] ALU_ADD = ALUW'(3'b000);
    localparam logic [ALUW-1:0] ALU_SUB = ALUW'(3'b001);
    localparam logic [ALUW-1:0] ALU_AND = ALUW'(3'b010);
    localparam logic [ALUW-1:0] ALU_ORR = ALUW'(3'b011);

    typedef struct packed {
        logic [3:0]      cond;
        logic [1:0]      flag_w;
        logic            branch;
        logic            pcsrc;
        logic            reg_write;
        logic            mem_w;
        logic            mem_to_reg;
        logic            alu_src;
        logic [ALUW-1:0] alu_control;
    } ctrl_e_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [3:0] cond_d;
    op_e        op_d;
    logic [5:0] funct_d;
    logic [3:0] rd_d;
    logic [3:0] cmd_d;
    logic       unused_rn;

    assign cond_d    = bus.InstrD[19:16];
    assign op_d      = op_e'(bus.InstrD[15:14]);
    assign funct_d   = bus.InstrD[13:8];
    assign rd_d      = bus.InstrD[3:0];
    assign cmd_d     = funct_d[4:1];
    // Rn is routed by the datapath; the controller never looks at it.
    assign unused_rn = ^bus.InstrD[7:4];

    logic [1:0]      reg_src_d;
    logic [1:0]      imm_src_d;
    logic            alu_src_d;
    logic [ALUW-1:0] alu_control_d;
    logic            reg_write_d;
    logic            mem_w_d;
    logic            mem_to_reg_d;
    logic            branch_d;
    logic [1:0]      flag_w_d;
    logic            pcsrc_d;

    always_comb begin
        reg_src_d     = 2'b00;
        imm_src_d     = 2'b00;
        alu_src_d     = 1'b0;
        alu_control_d = ALU_ADD;
        reg_write_d   = 1'b0;
        mem_w_d       = 1'b0;
        mem_to_reg_d  = 1'b0;
        branch_d      = 1'b0;
        flag_w_d      = 2'b00;

        case (op_d)
            OP_DP: begin
                alu_src_d = funct_d[5];
                case (cmd_d)
                    4'b0100: begin
                        alu_control_d = ALU_ADD;
                        reg_write_d   = 1'b1;
                        flag_w_d      = funct_d[0] ? 2'b11 : 2'b00;
                    end
                    4'b0010: begin
                        alu_control_d = ALU_SUB;
                        reg_write_d   = 1'b1;
                        flag_w_d      = funct_d[0] ? 2'b11 : 2'b00;
                    end
                    4'b0000: begin
                        alu_control_d = ALU_AND;
                        reg_write_d   = 1'b1;
                        flag_w_d      = funct_d[0] ? 2'b10 : 2'b00;
                    end
                    4'b1100: begin
                        alu_control_d = ALU_ORR;
                        reg_write_d   = 1'b1;
                        flag_w_d      = funct_d[0] ? 2'b10 : 2'b00;
                    end
                    4'b1010: begin
                        // CMP always updates flags regardless of the S bit.
                        alu_control_d = ALU_SUB;
                        flag_w_d      = 2'b11;
                    end
                    default: ;
                endcase
            end
            OP_MEM: begin
                imm_src_d = 2'b01;
                alu_src_d = 1'b1;
                if (funct_d[0]) begin
                    reg_write_d  = 1'b1;
                    mem_to_reg_d = 1'b1;
                end else begin
                    mem_w_d   = 1'b1;
                    reg_src_d = 2'b10;
                end
            end
            OP_BR: begin
                branch_d  = 1'b1;
                reg_src_d = 2'b01;
                imm_src_d = 2'b10;
                alu_src_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcsrc_d = ((rd_d == 4'hF) & reg_write_d) | branch_d;

    // ------------------------------------------------------------------
    // D->E register
    // ------------------------------------------------------------------
    ctrl_e_t ctrl_e;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e <= '0;
        end else if (bus.FlushE) begin
            ctrl_e <= '0;
        end else begin
            ctrl_e <= '{cond:        cond_d,
                        flag_w:      flag_w_d,
                        branch:      branch_d,
                        pcsrc:       pcsrc_d,
                        reg_write:   reg_write_d,
                        mem_w:       mem_w_d,
                        mem_to_reg:  mem_to_reg_d,
                        alu_src:     alu_src_d,
                        alu_control: alu_control_d};
        end
    end

    // ------------------------------------------------------------------
    // Execute: condition check and flag register
    // ------------------------------------------------------------------
    logic [1:0] flags_nz;
    logic [1:0] flags_cv;
    logic       fn, fz, fc, fv;
    logic       cond_ex_e;

    assign {fn, fz} = flags_nz;
    assign {fc, fv} = flags_cv;

    always_comb begin
        cond_ex_e = 1'b0;
        case (ctrl_e.cond)
            4'b0000: cond_ex_e = fz;
            4'b0001: cond_ex_e = ~fz;
            4'b0010: cond_ex_e = fc;
            4'b0011: cond_ex_e = ~fc;
            4'b0100: cond_ex_e = fn;
            4'b0101: cond_ex_e = ~fn;
            4'b0110: cond_ex_e = fv;
            4'b0111: cond_ex_e = ~fv;
            4'b1000: cond_ex_e = fc & ~fz;
            4'b1001: cond_ex_e = ~fc | fz;
            4'b1010: cond_ex_e = ~(fn ^ fv);
            4'b1011: cond_ex_e = fn ^ fv;
            4'b1100: cond_ex_e = ~fz & ~(fn ^ fv);
            4'b1101: cond_ex_e = fz | (fn ^ fv);
            4'b1110: cond_ex_e = 1'b1;
            default: cond_ex_e = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_nz <= 2'b00;
            flags_cv <= 2'b00;
        end else begin
            if (ctrl_e.flag_w[1] & cond_ex_e) flags_nz <= bus.ALUFlags[3:2];
            if (ctrl_e.flag_w[0] & cond_ex_e) flags_cv <= bus.ALUFlags[1:0];
        end
    end

    logic reg_write_eg;
    logic mem_w_eg;
    logic pcsrc_eg;

    assign reg_write_eg = ctrl_e.reg_write & cond_ex_e;
    assign mem_w_eg     = ctrl_e.mem_w & cond_ex_e;
    // A taken branch redirects via BranchTakenE; only R15 writes travel on.
    assign pcsrc_eg     = ctrl_e.pcsrc & cond_ex_e & ~ctrl_e.branch;

    // ------------------------------------------------------------------
    // E->M and M->W registers
    // ------------------------------------------------------------------
    logic pcsrc_m, reg_write_m, mem_w_m, mem_to_reg_m;
    logic pcsrc_w, reg_write_w, mem_to_reg_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcsrc_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            mem_w_m      <= 1'b0;
            mem_to_reg_m <= 1'b0;
            pcsrc_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
        end else begin
            pcsrc_m      <= pcsrc_eg;
            reg_write_m  <= reg_write_eg;
            mem_w_m      <= mem_w_eg;
            mem_to_reg_m <= ctrl_e.mem_to_reg;
            pcsrc_w      <= pcsrc_m;
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.RegSrcD      = reg_src_d;
    assign bus.ImmSrcD      = imm_src_d;
    assign bus.ALUSrcE      = ctrl_e.alu_src;
    assign bus.ALUControlE  = ctrl_e.alu_control;
    assign bus.MemtoRegE    = ctrl_e.mem_to_reg;
    assign bus.BranchTakenE = ctrl_e.branch & cond_ex_e;
    assign bus.MemWriteM    = mem_w_m;
    assign bus.RegWriteM    = reg_write_m;
    assign bus.PCSrcW       = pcsrc_w;
    assign bus.MemtoRegW    = mem_to_reg_w;
    assign bus.RegWriteW    = reg_write_w;
    assign bus.PCWrPendingF = pcsrc_d | pcsrc_eg | pcsrc_m;

endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller
//   Self-checking bench for pipe_controller: directed sequences with literal
//   expectations, then randomized instruction streams compared every cycle
//   against an instruction-level reference model.
module tb_pipe_controller;

    localparam logic [19:0] NOP    = 20'hF0000;
    localparam logic [19:0] ADD    = 20'hE0821;
    localparam logic [19:0] CMP    = 20'hE3510;
    localparam logic [19:0] BEQ    = 20'h0A000;
    localparam logic [19:0] LDR    = 20'hE5910;
    localparam logic [19:0] STR    = 20'hE5810;
    localparam logic [19:0] ADDNE  = 20'h10821;
    localparam logic [19:0] ADDPC  = 20'hE082F;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_controller_if #(.ALUW(3)) bus ();

    pipe_controller #(.ALUW(3)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // What an instruction asks for, straight from the ISA rules.
    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] reg_src;
        logic [1:0] imm_src;
        logic       alu_src;
        logic [2:0] alu;
        logic       rw;
        logic       mw;
        logic       m2r;
        logic       br;
        logic       pcsrc;
        logic [1:0] fw;
    } rec_t;

    function automatic rec_t decode(input logic [19:0] ins);
        rec_t r;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] cmd;
        r      = '0;
        r.cond = ins[19:16];
        op     = ins[15:14];
        funct  = ins[13:8];
        cmd    = funct[4:1];
        if (op == 2'd0) begin
            r.alu_src = funct[5];
            if (cmd == 4'b0100)      begin r.alu = 3'd0; r.rw = 1'b1; r.fw = funct[0] ? 2'b11 : 2'b00; end
            else if (cmd == 4'b0010) begin r.alu = 3'd1; r.rw = 1'b1; r.fw = funct[0] ? 2'b11 : 2'b00; end
            else if (cmd == 4'b0000) begin r.alu = 3'd2; r.rw = 1'b1; r.fw = funct[0] ? 2'b10 : 2'b00; end
            else if (cmd == 4'b1100) begin r.alu = 3'd3; r.rw = 1'b1; r.fw = funct[0] ? 2'b10 : 2'b00; end
            else if (cmd == 4'b1010) begin r.alu = 3'd1; r.fw = 2'b11; end
        end else if (op == 2'd1) begin
            r.imm_src = 2'b01;
            r.alu_src = 1'b1;
            if (funct[0]) begin r.rw = 1'b1; r.m2r = 1'b1; end
            else          begin r.mw = 1'b1; r.reg_src = 2'b10; end
        end else if (op == 2'd2) begin
            r.br      = 1'b1;
            r.reg_src = 2'b01;
            r.imm_src = 2'b10;
            r.alu_src = 1'b1;
        end
        r.pcsrc = ((ins[3:0] == 4'hF) && r.rw) || r.br;
        return r;
    endfunction

    // Condition pairs share a base test; odd codes are its negation.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        if (c == 4'hE) return 1'b1;
        return c[0] ? ~base : base;
    endfunction

    // Instruction occupying each later stage, with its fate once resolved.
    rec_t       pe = '0;
    rec_t       pm = '0;
    rec_t       pw = '0;
    logic [3:0] mflags = 4'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pe = '0; pm = '0; pw = '0; mflags = 4'h0;
        end else begin
            logic pass;
            pass     = cond_pass(pe.cond, mflags);
            pw       = pm;
            pm       = '0;
            pm.rw    = pe.rw & pass;
            pm.mw    = pe.mw & pass;
            pm.m2r   = pe.m2r;
            pm.pcsrc = pe.pcsrc & pass & ~pe.br;
            if (pe.fw[1] & pass) mflags[3:2] = bus.ALUFlags[3:2];
            if (pe.fw[0] & pass) mflags[1:0] = bus.ALUFlags[1:0];
            pe = bus.FlushE ? '0 : decode(bus.InstrD);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        #2;
        if (started) begin
            rec_t d;
            logic pass_e;
            d      = decode(bus.InstrD);
            pass_e = cond_pass(pe.cond, mflags);
            chk("RegSrcD",      32'(bus.RegSrcD),      32'(d.reg_src));
            chk("ImmSrcD",      32'(bus.ImmSrcD),      32'(d.imm_src));
            chk("ALUSrcE",      32'(bus.ALUSrcE),      32'(pe.alu_src));
            chk("ALUControlE",  32'(bus.ALUControlE),  32'(pe.alu));
            chk("MemtoRegE",    32'(bus.MemtoRegE),    32'(pe.m2r));
            chk("BranchTakenE", 32'(bus.BranchTakenE), 32'(pe.br & pass_e));
            chk("MemWriteM",    32'(bus.MemWriteM),    32'(pm.mw));
            chk("RegWriteM",    32'(bus.RegWriteM),    32'(pm.rw));
            chk("PCSrcW",       32'(bus.PCSrcW),       32'(pw.pcsrc));
            chk("MemtoRegW",    32'(bus.MemtoRegW),    32'(pw.m2r));
            chk("RegWriteW",    32'(bus.RegWriteW),    32'(pw.rw));
            chk("PCWrPendingF", 32'(bus.PCWrPendingF),
                32'(d.pcsrc | (pe.pcsrc & pass_e & ~pe.br) | pm.pcsrc));
        end
    end

    // ---------------- driver tasks ----------------
    // Presents one instruction in Decode for one cycle; returns shortly
    // after the negedge so literal checks see settled outputs.
    task automatic cyc(input logic [19:0] i, input logic [3:0] f, input logic fl, input logic r);
        @(negedge clk);
        bus.InstrD   = i;
        bus.ALUFlags = f;
        bus.FlushE   = fl;
        rst          = r;
        #3;
    endtask

    task automatic lit_all_zero();
        chk("rst_RegSrcD",      32'(bus.RegSrcD),      0);
        chk("rst_ImmSrcD",      32'(bus.ImmSrcD),      0);
        chk("rst_ALUSrcE",      32'(bus.ALUSrcE),      0);
        chk("rst_ALUControlE",  32'(bus.ALUControlE),  0);
        chk("rst_BranchTakenE", 32'(bus.BranchTakenE), 0);
        chk("rst_MemWriteM",    32'(bus.MemWriteM),    0);
        chk("rst_MemtoRegE",    32'(bus.MemtoRegE),    0);
        chk("rst_RegWriteM",    32'(bus.RegWriteM),    0);
        chk("rst_PCSrcW",       32'(bus.PCSrcW),       0);
        chk("rst_MemtoRegW",    32'(bus.MemtoRegW),    0);
        chk("rst_RegWriteW",    32'(bus.RegWriteW),    0);
        chk("rst_PCWrPendingF", 32'(bus.PCWrPendingF), 0);
    endtask

    function automatic logic [19:0] rand_instr();
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rn, rd;
        logic [3:0] cmds [5];
        cmds  = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
        cond  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
        op    = 2'($urandom_range(0, 3));
        funct = 6'($urandom_range(0, 63));
        if (op == 2'd0 && $urandom_range(0, 4) != 0)
            funct[4:1] = cmds[$urandom_range(0, 4)];
        rn = 4'($urandom_range(0, 15));
        rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        return {cond, op, funct, rn, rd};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bus.InstrD   = NOP;
        bus.ALUFlags = 4'h0;
        bus.FlushE   = 1'b0;
        started      = 1'b1;

        // Reset mid-stream with an ADD in flight.
        cyc(NOP, 4'h0, 1'b0, 1'b1);
        cyc(NOP, 4'h0, 1'b0, 1'b1);
        cyc(ADD, 4'h0, 1'b0, 1'b0);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        cyc(NOP, 4'h0, 1'b0, 1'b1);
        lit_all_zero();
        cyc(NOP, 4'h0, 1'b0, 1'b1);
        lit_all_zero();
        for (int k = 0; k < 3; k++) begin
            cyc(NOP, 4'h0, 1'b0, 1'b0);
            chk("post_rst_RegWriteW", 32'(bus.RegWriteW), 0);
        end

        // ADD R1,R2,R3
        cyc(ADD, 4'h0, 1'b0, 1'b0);
        chk("add_RegSrcD", 32'(bus.RegSrcD), 0);
        chk("add_ImmSrcD", 32'(bus.ImmSrcD), 0);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        chk("add_ALUControlE", 32'(bus.ALUControlE), 0);
        chk("add_ALUSrcE",     32'(bus.ALUSrcE),     0);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        chk("add_RegWriteW", 32'(bus.RegWriteW), 1);
        chk("add_MemtoRegW", 32'(bus.MemtoRegW), 0);

        // CMP R1,#5 then BEQ, with Z set and then clear.
        cyc(CMP, 4'h0, 1'b0, 1'b0);
        chk("cmp_ALUSrc_next_is_D", 32'(bus.ImmSrcD), 0);
        cyc(BEQ, 4'b0100, 1'b0, 1'b0);
        chk("cmp_ALUControlE", 32'(bus.ALUControlE), 1);
        chk("cmp_ALUSrcE",     32'(bus.ALUSrcE),     1);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        chk("beq_taken", 32'(bus.BranchTakenE), 1);
        cyc(CMP, 4'h0, 1'b0, 1'b0);
        cyc(BEQ, 4'b0000, 1'b0, 1'b0);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        chk("beq_not_taken", 32'(bus.BranchTakenE), 0);

        // LDR then STR
        cyc(LDR, 4'h0, 1'b0, 1'b0);
        chk("ldr_ImmSrcD", 32'(bus.ImmSrcD), 1);
        cyc(STR, 4'h0, 1'b0, 1'b0);
        chk("ldr_MemtoRegE", 32'(bus.MemtoRegE), 1);
        chk("str_RegSrcD",   32'(bus.RegSrcD),   2);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        chk("str_MemWriteM", 32'(bus.MemWriteM), 1);
        chk("ldr_RegWriteW", 32'(bus.RegWriteW), 1);
        chk("ldr_MemtoRegW", 32'(bus.MemtoRegW), 1);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        chk("str_RegWriteW", 32'(bus.RegWriteW), 0);

        // ADDNE after CMP that set Z: squashed, flags left alone.
        cyc(CMP, 4'h0, 1'b0, 1'b0);
        cyc(ADDNE, 4'b0100, 1'b0, 1'b0);
        cyc(NOP, 4'b0000, 1'b0, 1'b0);
        chk("addne_BranchTakenE", 32'(bus.BranchTakenE), 0);
        cyc(BEQ, 4'h0, 1'b0, 1'b0);
        chk("addne_RegWriteM", 32'(bus.RegWriteM), 0);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        chk("addne_RegWriteW",   32'(bus.RegWriteW),    0);
        chk("addne_flags_kept",  32'(bus.BranchTakenE), 1);

        // ADD R15 through the pipe, then the same with a flush.
        for (int k = 0; k < 3; k++) cyc(NOP, 4'h0, 1'b0, 1'b0);
        cyc(ADDPC, 4'h0, 1'b0, 1'b0);
        chk("pc_pending_D", 32'(bus.PCWrPendingF), 1);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        chk("pc_pending_E", 32'(bus.PCWrPendingF), 1);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        chk("pc_pending_M", 32'(bus.PCWrPendingF), 1);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        chk("pc_PCSrcW",    32'(bus.PCSrcW),       1);
        chk("pc_RegWriteW", 32'(bus.RegWriteW),    1);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        cyc(ADDPC, 4'h0, 1'b1, 1'b0);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        chk("flush_pending_E", 32'(bus.PCWrPendingF), 0);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        cyc(NOP, 4'h0, 1'b0, 1'b0);
        chk("flush_PCSrcW",    32'(bus.PCSrcW),    0);
        chk("flush_RegWriteW", 32'(bus.RegWriteW), 0);

        // Randomized stream with occasional flushes and resets.
        for (int k = 0; k < 3000; k++) begin
            cyc(rand_instr(), 4'($urandom_range(0, 15)),
                $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end
        cyc(NOP, 4'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
